// File: rtl/overlay_sequencer.sv
// Staged channel reveal and optional blink for end-of-game overlays.
// Define OVERLAY_BLINK_EN to compile in the SHOW-state blink gating.
module overlay_sequencer #(
    parameter int N_CH = 3,
    parameter int RGB_W = 8,
    parameter int REVEAL_FRAMES = 30,
    parameter int BLINK_FRAMES = 16,
    parameter logic [N_CH-1:0] BLINK_MASK = N_CH'(1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  enable,
    input  logic [N_CH-1:0]       chDR,
    input  logic [N_CH*RGB_W-1:0] chRGB,
    output logic                  overlayDR,
    output logic [RGB_W-1:0]      overlayRGB,
    output logic                  revealDone
);

    localparam int CW = $clog2(N_CH + 1);
    localparam int FW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_t;

    state_t state, nextState;
    logic [CW-1:0] visCount, nextVisCount;
    logic [FW-1:0] frameCnt, nextFrameCnt;
    logic [N_CH-1:0] visible, gateOff, qual;
    logic muxDR;
    logic [RGB_W-1:0] muxRGB;

`ifdef OVERLAY_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blinkCnt, nextBlinkCnt;
    logic phase, nextPhase;
`endif

    always_comb begin
        nextState = state;
        nextVisCount = visCount;
        nextFrameCnt = frameCnt;
`ifdef OVERLAY_BLINK_EN
        nextBlinkCnt = blinkCnt;
        nextPhase = phase;
`endif
        if (!enable) begin
            nextState = IDLE;
            nextVisCount = '0;
            nextFrameCnt = '0;
`ifdef OVERLAY_BLINK_EN
            nextBlinkCnt = '0;
            nextPhase = 1'b0;
`endif
        end else if (startOfFrame) begin
            unique case (state)
                IDLE: begin
                    nextState = REVEAL;
                    nextVisCount = CW'(1);
                    nextFrameCnt = '0;
                end
                REVEAL: begin
                    // Single-channel builds are already fully visible.
                    if (visCount >= CW'(N_CH)) begin
                        nextState = SHOW;
                        nextFrameCnt = '0;
                    end else if (frameCnt == FW'(REVEAL_FRAMES - 1)) begin
                        nextFrameCnt = '0;
                        nextVisCount = visCount + CW'(1);
                        if (visCount == CW'(N_CH - 1)) nextState = SHOW;
                    end else begin
                        nextFrameCnt = frameCnt + FW'(1);
                    end
`ifdef OVERLAY_BLINK_EN
                    if (nextState == SHOW) begin
                        nextBlinkCnt = '0;
                        nextPhase = 1'b1;
                    end
`endif
                end
                SHOW: begin
`ifdef OVERLAY_BLINK_EN
                    if (blinkCnt == BW'(BLINK_FRAMES - 1)) begin
                        nextBlinkCnt = '0;
                        nextPhase = ~phase;
                    end else begin
                        nextBlinkCnt = blinkCnt + BW'(1);
                    end
`endif
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        visible = '0;
        for (int i = 0; i < N_CH; i++) begin
            visible[i] = (state == SHOW) ||
                         ((state == REVEAL) && (CW'(i) < visCount));
        end
    end

`ifdef OVERLAY_BLINK_EN
    assign gateOff = {N_CH{(state == SHOW) && !phase}} & BLINK_MASK;
`else
    // Blink parameters are inert here; the term is constant zero.
    localparam logic [N_CH-1:0] NO_BLINK =
        BLINK_MASK & {N_CH{BLINK_FRAMES < 1}};
    assign gateOff = {N_CH{state == SHOW}} & NO_BLINK;
`endif

    assign qual = chDR & visible & ~gateOff & {N_CH{enable}};

    // Scan high to low so the lowest qualifying index wins.
    always_comb begin
        muxDR = 1'b0;
        muxRGB = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (qual[i]) begin
                muxDR = 1'b1;
                muxRGB = chRGB[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            visCount <= '0;
            frameCnt <= '0;
            overlayDR <= 1'b0;
            overlayRGB <= '0;
        end else begin
            state <= nextState;
            visCount <= nextVisCount;
            frameCnt <= nextFrameCnt;
            overlayDR <= muxDR;
            overlayRGB <= muxRGB;
        end
    end

`ifdef OVERLAY_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blinkCnt <= '0;
            phase <= 1'b0;
        end else begin
            blinkCnt <= nextBlinkCnt;
            phase <= nextPhase;
        end
    end
`endif

    assign revealDone = (state == SHOW);

endmodule

// File: tb/tb_overlay_sequencer.sv
// Randomized bench for overlay_sequencer against a frame-counting model.
// Two instances: 3 channels / 2 reveal frames, and 1 channel / 1 frame.
module tb_overlay_sequencer;

    localparam int RF = 2;
    localparam int BF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, startOfFrame, enable;
    logic [2:0] chDR;
    logic [23:0] chRGB;
    logic dr0, done0, dr1, done1;
    logic [7:0] rgb0, rgb1;

    overlay_sequencer #(
        .N_CH(3), .RGB_W(8), .REVEAL_FRAMES(RF),
        .BLINK_FRAMES(BF), .BLINK_MASK(3'b001)
    ) dut0 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .enable(enable), .chDR(chDR), .chRGB(chRGB),
        .overlayDR(dr0), .overlayRGB(rgb0), .revealDone(done0)
    );

    overlay_sequencer #(
        .N_CH(1), .RGB_W(8), .REVEAL_FRAMES(1),
        .BLINK_FRAMES(BF), .BLINK_MASK(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .enable(enable), .chDR(chDR[0]), .chRGB(chRGB[7:0]),
        .overlayDR(dr1), .overlayRGB(rgb1), .revealDone(done1)
    );

    // mode: 0 idle, 1 revealing, 2 showing; frames = frame edges since entry
    typedef struct {
        int mode;
        int frames;
    } mdl_t;

    mdl_t m0, m1;
    int vectors = 0;
    int miscompares = 0;
    logic [19:0] expv, obsv;

    function automatic mdl_t step(mdl_t m, int nCh, int rf,
                                  logic rst, logic en, logic sof);
        int need;
        need = (nCh - 1) * rf;
        if (need < 1) need = 1;
        if (rst || !en) begin
            m.mode = 0;
            m.frames = 0;
        end else if (sof) begin
            if (m.mode == 0) begin
                m.mode = 1;
                m.frames = 0;
            end else if (m.mode == 1) begin
                m.frames++;
                if (m.frames >= need) begin
                    m.mode = 2;
                    m.frames = 0;
                end
            end else begin
                m.frames++;
            end
        end
        return m;
    endfunction

    function automatic logic [8:0] pick(mdl_t m, int nCh, int rf,
                                        logic [2:0] mask, logic en,
                                        logic [2:0] dr, logic [23:0] rgb);
        logic [8:0] r;
        logic vis, off;
        r = '0;
        if (m.mode == 0 || !en) return r;
        for (int i = nCh - 1; i >= 0; i--) begin
            vis = (m.mode == 2) || (i < 1 + m.frames / rf);
            off = 1'b0;
`ifdef OVERLAY_BLINK_EN
            off = (m.mode == 2) && mask[i] && ((m.frames / BF) % 2 == 1);
`endif
            if (dr[i] && vis && !off) r = {1'b1, rgb[i*8 +: 8]};
        end
        return r;
    endfunction

    task automatic cycle(input logic rst, input logic en, input logic sof,
                         input logic [2:0] dr, input logic [23:0] rgb);
        logic [8:0] e0, e1;
        @(negedge clk);
        reset = rst;
        enable = en;
        startOfFrame = sof;
        chDR = dr;
        chRGB = rgb;
        e0 = rst ? 9'd0 : pick(m0, 3, RF, 3'b001, en, dr, rgb);
        e1 = rst ? 9'd0 : pick(m1, 1, 1, 3'b001, en, dr & 3'b001, rgb);
        m0 = step(m0, 3, RF, rst, en, sof);
        m1 = step(m1, 1, 1, rst, en, sof);
        expv = {e0, m0.mode == 2, e1, m1.mode == 2};
        @(posedge clk);
        #1;
        obsv = {dr0, rgb0, done0, dr1, rgb1, done1};
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, k[0], 3'($urandom), 24'($urandom));
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL reset: got %h expected %h", obsv, expv);
            end
        end
    endtask

    task automatic test_reveal();
        for (int k = 0; k < 28; k++) begin
            cycle(1'b0, 1'b1, (k % 4) == 0, 3'b111, 24'h1C_E0_35);
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL reveal cyc%0d: got %h expected %h",
                         k, obsv, expv);
            end
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'b110, 24'h1C_E0_77);
            vectors++;
            if (obsv !== expv || rgb0 !== 8'hE0 || done0 !== 1'b1) begin
                miscompares++;
                $display("FAIL priority: got %h expected %h rgb0 %h need e0",
                         obsv, expv, rgb0);
            end
        end
    endtask

    task automatic test_blink();
        int onCnt = 0;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 1'b1, (k % 3) == 0, 3'b001, 24'($urandom));
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL blink cyc%0d: got %h expected %h",
                         k, obsv, expv);
            end
            if (dr0) onCnt++;
        end
        vectors++;
`ifdef OVERLAY_BLINK_EN
        if (onCnt < 20 || onCnt > 40) begin
`else
        if (onCnt != 60) begin
`endif
            miscompares++;
            $display("FAIL blink duty: got %0d on cycles of 60", onCnt);
        end
    endtask

    task automatic test_enable_drop();
        cycle(1'b1, 1'b1, 1'b0, 3'b111, 24'h030201);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, (k % 3) == 0, 3'b111, 24'h030201);
        end
        cycle(1'b0, 1'b0, 1'b1, 3'b111, 24'h030201);
        vectors++;
        if (obsv !== expv || dr0 !== 1'b0 || done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop: got %h expected %h", obsv, expv);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'b111, 24'h030201);
            vectors++;
            if (obsv !== expv || dr0 !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold: got %h expected %h", obsv, expv);
            end
        end
    endtask

    task automatic test_reset_mid_show();
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, (k % 2) == 0, 3'b111, 24'h0A0B0C);
        end
        cycle(1'b1, 1'b1, 1'b0, 3'b111, 24'h0A0B0C);
        vectors++;
        if (obsv !== expv || obsv !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_show: got %h expected %h", obsv, expv);
        end
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b1, (k % 3) == 0, 3'b111, 24'h0A0B0C);
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL restart cyc%0d: got %h expected %h",
                         k, obsv, expv);
            end
        end
    endtask

    task automatic test_random();
        logic rst, en, sof;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(199) == 0);
            en = ($urandom_range(59) != 0);
            sof = ($urandom_range(3) == 0);
            cycle(rst, en, sof, 3'($urandom), 24'($urandom));
            vectors++;
            if (obsv !== expv) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h expected %h",
                         k, obsv, expv);
            end
        end
    endtask

    initial begin
        m0 = '{0, 0};
        m1 = '{0, 0};
        reset = 1'b1;
        enable = 1'b0;
        startOfFrame = 1'b0;
        chDR = '0;
        chRGB = '0;
        test_reset();
        test_reveal();
        test_priority();
        test_blink();
        test_enable_drop();
        test_reset_mid_show();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/overlay_sequencer.md
OVERLAY_SEQUENCER -- requirements
Module: overlay_sequencer

Interface
REQ-001 Parameter N_CH, default 3, number of bitmap channels composed (legal 1..8).
REQ-002 Parameter RGB_W, default 8, colour width per channel.
REQ-003 Parameter REVEAL_FRAMES, default 30, frames between successive channel reveals (legal >= 1).
REQ-004 Parameter BLINK_FRAMES, default 16, frames per blink half-period (legal >= 1).
REQ-005 Parameter BLINK_MASK, default 3'b001 (N_CH bits), channels subject to blinking.
REQ-006 clk  in  1  system pixel clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-009 enable  in  1  overlay active, e.g. game ended; level-sensitive.
REQ-010 chDR  in  N_CH  per-channel drawing request from the bitmap objects.
REQ-011 chRGB  in  N_CH*RGB_W  packed colours; channel i at bits [i*RGB_W +: RGB_W].
REQ-012 overlayDR  out  1  registered composed drawing request.
REQ-013 overlayRGB  out  RGB_W  registered composed colour.
REQ-014 revealDone  out  1  high while all channels are revealed (state SHOW).

Function
REQ-015 FSM states SHALL be IDLE, REVEAL and SHOW.
REQ-016 IDLE -> REVEAL on the first startOfFrame with enable=1; visCount SHALL load 1 and frameCnt SHALL load 0.
REQ-017 In REVEAL, each startOfFrame SHALL increment frameCnt; when frameCnt reaches REVEAL_FRAMES-1, frameCnt SHALL clear and visCount SHALL increment.
REQ-018 REVEAL -> SHOW on the same frame edge on which visCount would reach N_CH; with N_CH=1, REVEAL -> SHOW on the first frame edge in REVEAL.
REQ-019 visCount SHALL saturate at N_CH and never wrap.
REQ-020 Channel i SHALL be visible when i < visCount in REVEAL, and always in SHOW.
REQ-021 In SHOW, blinkCnt SHALL count startOfFrame pulses; at BLINK_FRAMES-1 it SHALL clear and the blink phase SHALL toggle; phase SHALL be 1 (on) on entry to SHOW.
REQ-022 A channel in BLINK_MASK SHALL be gated off while phase=0; unmasked channels SHALL be unaffected.
REQ-023 enable=0 in any state SHALL force IDLE on the next clock edge and clear all counters; this overrides a simultaneous startOfFrame.
REQ-024 Mux priority SHALL go to the lowest index i where chDR[i], visible and not gated; overlayRGB SHALL take that channel's colour and overlayDR SHALL be 1.
REQ-025 When no channel qualifies, overlayDR SHALL be 0 and overlayRGB SHALL be 0.
REQ-026 Mux latency SHALL be exactly 1 clk from chDR/chRGB to overlayDR/overlayRGB.
REQ-027 In IDLE, overlayDR SHALL be 0 regardless of chDR.
REQ-028 State, visCount and phase changes SHALL take effect only on startOfFrame edges (except REQ-023), so no frame is torn.

Reset
REQ-029 reset SHALL put the FSM in IDLE and clear visCount, frameCnt, blinkCnt and phase.
REQ-030 On reset, overlayDR, overlayRGB and revealDone SHALL all be 0 from the first edge on which reset is sampled high.
REQ-031 Reset SHALL take effect mid-REVEAL or mid-SHOW identically.

Configuration
REQ-032 Macro OVERLAY_BLINK_EN, when defined, SHALL compile in blinkCnt, phase and BLINK_MASK gating.
REQ-033 When OVERLAY_BLINK_EN is undefined, all visible channels SHALL be always drawn in SHOW; BLINK_FRAMES and BLINK_MASK SHALL be ignored.

Verification
REQ-034 N_CH=3, REVEAL_FRAMES=2, enable=1, all chDR=1 -> overlay shows ch0 only for 2 frames, ch0/1 for 2 frames, then SHOW with revealDone=1.
REQ-035 In SHOW, chDR=3'b110, chRGB ch1=8'hE0, ch2=8'h1C -> overlayRGB=8'hE0 one clk later (priority).
REQ-036 OVERLAY_BLINK_EN defined, BLINK_FRAMES=4, BLINK_MASK=3'b001, only chDR[0]=1 -> overlayDR on 4 frames, off 4 frames, repeating; undefined -> always on.
REQ-037 enable dropped in the same cycle as startOfFrame during REVEAL -> IDLE next edge, overlayDR=0, revealDone=0.
REQ-038 reset pulsed mid-SHOW -> all outputs 0 next edge; with enable held high, REVEAL restarts at visCount=1 on the next startOfFrame.
REQ-039 N_CH=1, REVEAL_FRAMES=1 -> SHOW entered on the first frame edge after entering REVEAL; visCount never exceeds 1.
